shift_word_rx: RTL and testbench
================================

# shift_word_rx

Serial-to-parallel word receiver: the receiving end of a bit-serial path whose transmitter is a chain of mc10141 shift registers clocked in SHIFTR mode, MSB (bit 0) first. Frames of WIDTH strobed bits are assembled into a parallel word in PDP-10 bit order and presented on a one-deep holding register with a valid/taken handshake. It sits between serial diagnostic/console links and the parallel word buses that consume them. It reports overrun and framing errors as sticky flags.

## Interface
- WIDTH, 36, data bits per frame (≥2)
- clk  in  1  rising-edge clock
- resetN  in  1  asynchronous, active-low reset
- serBit  in  1  serial data bit, sampled only when serStrobe=1
- serStrobe  in  1  bit-valid qualifier; gaps of any length allowed
- serStart  in  1  frame marker, asserted together with the strobe of bit 0
- wordOut  out  [0:WIDTH-1]  received word; bit 0 is the first bit received
- wordValid  out  1  wordOut holds an unconsumed word
- wordTaken  in  1  consumer accepts wordOut (honoured only while wordValid=1)
- busy  out  1  frame in progress (state ≠ IDLE)
- overrun  out  1  sticky: completed frame dropped because the holding register was full
- framingErr  out  1  sticky: strobe without serStart in IDLE, or serStart mid-frame
- clrErr  in  1  synchronous clear of overrun and framingErr
- parityErr  out  1  parity result for wordOut (see Configuration)

## Operation
- Reset: state IDLE, count 0, shifter 0, wordOut 0, wordValid 0, busy 0, overrun 0, framingErr 0, parityErr 0.
- Shifter assembly: each accepted bit enters at position WIDTH-1 and prior contents move one position toward bit 0; after WIDTH bits the first bit is in bit 0.
- IDLE: serStrobe & serStart → load bit, count=1, go SHIFT. serStrobe without serStart → bit discarded, framingErr set. No strobe → stay.
- SHIFT: serStrobe & ~serStart → shift bit in, count+1. serStrobe & serStart → framingErr set, frame restarts with this bit as bit 0 (count=1). When the accepted bit is bit WIDTH-1: go PARITY if enabled, else complete frame, go IDLE.
- Frame completion: if wordValid=0, or wordValid=1 with wordTaken=1 in the same cycle → wordOut ← shifter, wordValid=1. Otherwise → new word dropped, wordOut unchanged, wordValid stays 1, overrun set.
- wordTaken with wordValid=1 and no completion → wordValid cleared; wordOut keeps its value. wordTaken with wordValid=0 → ignored.
- clrErr clears both sticky flags; a set event in the same cycle wins (flag stays 1).
- No timeout; a partial frame waits indefinitely.

## Timing
- All state and outputs are registered on rising clk; no combinational input-to-output paths.
- wordValid and wordOut update on the same edge that samples the final bit (the parity bit when enabled); consumer sees them the following cycle.
- Back-to-back frames with no idle cycles are supported: serStart on the strobe immediately after the last bit of the previous frame.
- busy rises on the edge sampling bit 0 and falls on the edge sampling the final bit.
- resetN assertion mid-frame aborts immediately: partial frame discarded, all outputs to reset values.

## Configuration
- SHIFT_WORD_RX_PARITY_EN defined: one extra strobed bit follows data bit WIDTH-1 (state PARITY). Odd parity: parityErr=1 when the count of ones over the data bits plus parity bit is even. parityErr loads with wordOut (per-word, not sticky); it is unchanged when a word is dropped. serStart on the parity strobe → framingErr, restart as in SHIFT.
- Undefined: no PARITY state; frame is exactly WIDTH bits; parityErr tied 0.

## Test plan
- Reset, then frame 36'o777000777000 strobed every cycle → after 36th edge wordValid=1, wordOut=36'o777000777000, busy=0, flags 0.
- Same frame with serStrobe every third cycle, serBit toggling on non-strobe cycles → identical wordOut, wordValid only after 36th strobe.
- Two frames 36'o1 and 36'o2 with no wordTaken → wordOut=36'o1, overrun=1; clrErr → overrun=0; repeat with wordTaken on the second completion cycle → wordOut=36'o2, overrun=0.
- serStart reasserted on strobe 11 of a frame, then 35 more bits of 36'o525252525252 → framingErr=1, wordOut=36'o525252525252.
- resetN low after 20 bits, then full frame 36'o123456701234 → busy/wordValid 0 during reset, then wordOut=36'o123456701234.
- SHIFT_WORD_RX_PARITY_EN: 36'o000000000001 with parity bit 0 → parityErr=0; with parity bit 1 → parityErr=1; wordOut=36'o1 in both.

Source files
------------

// File: rtl/shift_word_rx.sv
// shift_word_rx: serial-to-parallel word receiver, bit 0 first, one-deep holding register.
// Define SHIFT_WORD_RX_PARITY_EN to append an odd-parity bit to every frame.
module shift_word_rx #(
  parameter int WIDTH = 36
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             serBit,
  input  logic             serStrobe,
  input  logic             serStart,
  output logic [0:WIDTH-1] wordOut,
  output logic             wordValid,
  input  logic             wordTaken,
  output logic             busy,
  output logic             overrun,
  output logic             framingErr,
  input  logic             clrErr,
  output logic             parityErr
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [0:WIDTH-1] sh_q;
  logic [0:WIDTH-1] sh_d;
  logic [0:WIDTH-1] word_d;
  logic             last;
  logic             done;
  logic             load;
  logic             fe_ev;
  logic             ov_ev;

  assign sh_d = {sh_q[1:WIDTH-1], serBit};
  assign last = (cnt_q == CW'(WIDTH - 1));

`ifdef SHIFT_WORD_RX_PARITY_EN
  assign word_d = sh_q;
`else
  assign word_d = sh_d;
`endif

  always_comb begin
    fe_ev = 1'b0;
    done  = 1'b0;
    if (serStrobe) begin
      if (state_q == IDLE) fe_ev = ~serStart;
      else                 fe_ev = serStart;
    end
`ifdef SHIFT_WORD_RX_PARITY_EN
    done = serStrobe & ~serStart & (state_q == PARITY);
`else
    done = serStrobe & ~serStart & (state_q == SHIFT) & last;
`endif
    load  = done & (~wordValid | wordTaken);
    ov_ev = done & wordValid & ~wordTaken;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      busy       <= 1'b0;
      wordOut    <= '0;
      wordValid  <= 1'b0;
      overrun    <= 1'b0;
      framingErr <= 1'b0;
    end else begin
      // serStart always (re)starts a frame, in any state
      if (serStrobe) begin
        if (serStart) begin
          state_q <= SHIFT;
          cnt_q   <= CW'(1);
          sh_q    <= sh_d;
          busy    <= 1'b1;
        end else begin
          case (state_q)
            IDLE: ;
            SHIFT: begin
              sh_q  <= sh_d;
              cnt_q <= cnt_q + CW'(1);
              if (last) begin
`ifdef SHIFT_WORD_RX_PARITY_EN
                state_q <= PARITY;
`else
                state_q <= IDLE;
                cnt_q   <= '0;
                busy    <= 1'b0;
`endif
              end
            end
            PARITY: begin
              state_q <= IDLE;
              cnt_q   <= '0;
              busy    <= 1'b0;
            end
            default: begin
              state_q <= IDLE;
              cnt_q   <= '0;
              busy    <= 1'b0;
            end
          endcase
        end
      end

      if (load) begin
        wordOut   <= word_d;
        wordValid <= 1'b1;
      end else if (!done && wordTaken) begin
        wordValid <= 1'b0;
      end

      overrun    <= ov_ev | (overrun & ~clrErr);
      framingErr <= fe_ev | (framingErr & ~clrErr);
    end
  end

`ifdef SHIFT_WORD_RX_PARITY_EN
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) parityErr <= 1'b0;
    else if (load) parityErr <= ~(^sh_q ^ serBit);
  end
`else
  assign parityErr = 1'b0;
`endif

endmodule

// File: tb/tb_shift_word_rx.sv
// tb_shift_word_rx: directed frames with hand-computed words and flags.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_shift_word_rx;

  localparam int W = 36;

  logic         clk = 1'b0;
  logic         resetN;
  logic         serBit;
  logic         serStrobe;
  logic         serStart;
  logic [0:W-1] wordOut;
  logic         wordValid;
  logic         wordTaken;
  logic         busy;
  logic         overrun;
  logic         framingErr;
  logic         clrErr;
  logic         parityErr;

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  shift_word_rx #(.WIDTH(W)) dut (
    .clk        (clk),
    .resetN     (resetN),
    .serBit     (serBit),
    .serStrobe  (serStrobe),
    .serStart   (serStart),
    .wordOut    (wordOut),
    .wordValid  (wordValid),
    .wordTaken  (wordTaken),
    .busy       (busy),
    .overrun    (overrun),
    .framingErr (framingErr),
    .clrErr     (clrErr),
    .parityErr  (parityErr)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0o expected %0o", tag, got, exp);
  endtask

  task automatic strobe(input logic b, input logic st);
    serBit    = b;
    serStrobe = 1'b1;
    serStart  = st;
    @(negedge clk);
    serStrobe = 1'b0;
    serStart  = 1'b0;
  endtask

  task automatic send_bits(input logic [0:W-1] w, input int lo,
                           input int hi, input int gap);
    for (int i = lo; i <= hi; i++) begin
      strobe(w[i], i == 0);
      for (int g = 0; g < gap; g++) begin
        serBit = ~serBit;
        @(negedge clk);
      end
    end
  endtask

  // last data bit (plus parity bit when enabled) with optional take
  task automatic tail(input logic [0:W-1] w, input logic tk);
`ifdef SHIFT_WORD_RX_PARITY_EN
    strobe(w[W-1], 1'b0);
    wordTaken = tk;
    strobe(~^w, 1'b0);
`else
    wordTaken = tk;
    strobe(w[W-1], 1'b0);
`endif
    wordTaken = 1'b0;
  endtask

  task automatic take();
    wordTaken = 1'b1;
    @(negedge clk);
    wordTaken = 1'b0;
  endtask

  task automatic clear();
    clrErr = 1'b1;
    @(negedge clk);
    clrErr = 1'b0;
  endtask

  logic [0:W-1] w;

  initial begin
    resetN    = 1'b0;
    serBit    = 1'b0;
    serStrobe = 1'b0;
    serStart  = 1'b0;
    wordTaken = 1'b0;
    clrErr    = 1'b0;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);

    check("rst_valid", wordValid, 0);
    check("rst_word", wordOut, 0);
    check("rst_busy", busy, 0);
    check("rst_flags", {overrun, framingErr, parityErr}, 0);

    // full-rate frame
    w = 36'o777000777000;
    send_bits(w, 0, 0, 0);
    check("busy_rise", busy, 1);
    send_bits(w, 1, W - 2, 0);
    check("valid_early", wordValid, 0);
    tail(w, 1'b0);
    check("f1_valid", wordValid, 1);
    check("f1_word", wordOut, 36'o777000777000);
    check("f1_busy", busy, 0);
    check("f1_flags", {overrun, framingErr}, 0);
    take();
    check("take_valid", wordValid, 0);
    check("take_word", wordOut, 36'o777000777000);

    // sparse strobes with noise on serBit between strobes
    send_bits(w, 0, W - 2, 2);
    check("gap_early", wordValid, 0);
    tail(w, 1'b0);
    check("gap_valid", wordValid, 1);
    check("gap_word", wordOut, 36'o777000777000);
    take();

    // back-to-back frames, no take -> overrun
    w = 36'o1;
    send_bits(w, 0, W - 2, 0);
    tail(w, 1'b0);
    w = 36'o2;
    send_bits(w, 0, W - 2, 0);
    tail(w, 1'b0);
    check("ovr_word", wordOut, 36'o1);
    check("ovr_flag", overrun, 1);
    check("ovr_valid", wordValid, 1);
    clear();
    check("ovr_clr", overrun, 0);

    // clear collides with a new overrun: set wins
    send_bits(w, 0, W - 2, 0);
    clrErr = 1'b1;
    tail(w, 1'b0);
    clrErr = 1'b0;
    check("ovr_setwins", overrun, 1);
    check("ovr_keep", wordOut, 36'o1);
    clear();

    // take on the completing edge accepts the new word
    take();
    w = 36'o1;
    send_bits(w, 0, W - 2, 0);
    tail(w, 1'b0);
    w = 36'o2;
    send_bits(w, 0, W - 2, 0);
    tail(w, 1'b1);
    check("tk_word", wordOut, 36'o2);
    check("tk_ovr", overrun, 0);
    check("tk_valid", wordValid, 1);
    take();

    // serStart on strobe 11 restarts the frame
    w = 36'o525252525252;
    send_bits(w, 0, 9, 0);
    send_bits(w, 0, W - 2, 0);
    tail(w, 1'b0);
    check("fe_flag", framingErr, 1);
    check("fe_word", wordOut, 36'o525252525252);
    check("fe_ovr", overrun, 0);
    clear();
    check("fe_clr", framingErr, 0);

    // stray strobe in IDLE
    strobe(1'b1, 1'b0);
    check("fe_idle", framingErr, 1);
    check("fe_idle_busy", busy, 0);
    clear();
    take();

    // reset mid-frame
    w = 36'o777777777777;
    send_bits(w, 0, 19, 0);
    resetN = 1'b0;
    #1;
    check("ar_busy", busy, 0);
    check("ar_valid", wordValid, 0);
    check("ar_word", wordOut, 0);
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    w = 36'o123456701234;
    send_bits(w, 0, W - 2, 0);
    tail(w, 1'b0);
    check("ar_word2", wordOut, 36'o123456701234);
    check("ar_valid2", wordValid, 1);
    check("ar_flags", {overrun, framingErr}, 0);
    take();

`ifdef SHIFT_WORD_RX_PARITY_EN
    w = 36'o1;
    send_bits(w, 0, W - 1, 0);
    strobe(1'b0, 1'b0);
    check("par0_err", parityErr, 0);
    check("par0_word", wordOut, 36'o1);
    take();
    send_bits(w, 0, W - 1, 0);
    strobe(1'b1, 1'b0);
    check("par1_err", parityErr, 1);
    check("par1_word", wordOut, 36'o1);
    take();
`else
    check("par_tied", parityErr, 0);
`endif

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
